// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and stall/flush controls between the pipeline and its hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic data_nstall, branch_taken, dmem_req, dmem_ready, mem_fault_clr;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic mem_abort, mem_fault;
  logic [CNT_W-1:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;
  modport master (
    output data_nstall, branch_taken, dmem_req, dmem_ready, mem_fault_clr,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush,
    input  mem_abort, mem_fault, lu_stall_cnt, flush_cnt, mem_wait_cnt
  );
  modport slave (
    input  data_nstall, branch_taken, dmem_req, dmem_ready, mem_fault_clr,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush,
    output mem_abort, mem_fault, lu_stall_cnt, flush_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush arbitration with a timed data-memory freeze FSM.
// Define PIPE_PERF_CNT_EN to implement the saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, WAIT} state_e;
  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);
  state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic fault_q, miss, timeout, freeze, br_c, lu_c, run_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      fault_q <= timeout | (fault_q & ~bus.mem_fault_clr);
    end
  end
  // a ready or dropped request leaves WAIT cleanly; only a still-pending miss at the limit aborts
  always_comb begin
    miss = bus.dmem_req & ~bus.dmem_ready;
    timeout = (state_q == WAIT) & miss & (wait_q == LIMIT);
    freeze = miss & ~timeout;
    state_d = freeze ? WAIT : RUN;
    wait_d = (state_q == WAIT) & freeze ? wait_q + 8'd1 : 8'd0;
    run_c = ~rst & ~freeze;
    br_c = run_c & bus.branch_taken;
    lu_c = run_c & ~bus.branch_taken & ~bus.data_nstall;
  end
  assign bus.pc_we = run_c & ~lu_c;
  assign bus.if_id_we = run_c & ~lu_c;
  assign bus.id_ex_we = run_c;
  assign bus.ex_mem_we = run_c;
  assign bus.if_id_flush = rst | br_c;
  assign bus.id_ex_flush = rst | br_c | lu_c;
  assign bus.mem_wb_flush = rst | freeze;
  assign bus.mem_abort = ~rst & timeout;
  assign bus.mem_fault = fault_q;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] lu_q, fl_q, mw_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q <= '0;
      fl_q <= '0;
      mw_q <= '0;
    end else begin
      if (lu_c & ~&lu_q) lu_q <= lu_q + CNT_W'(1);
      if (br_c & ~&fl_q) fl_q <= fl_q + CNT_W'(1);
      if (freeze & ~&mw_q) mw_q <= mw_q + CNT_W'(1);
    end
  end
  assign bus.lu_stall_cnt = lu_q;
  assign bus.flush_cnt = fl_q;
  assign bus.mem_wait_cnt = mw_q;
`else
  assign bus.lu_stall_cnt = '0;
  assign bus.flush_cnt = '0;
  assign bus.mem_wait_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for stall, branch, memory wait, timeout and reset behaviour
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif
  // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush, mem_abort}
  localparam logic [7:0] NORM = 8'b1111_0000;
  localparam logic [7:0] RSTV = 8'b0000_1110;
  localparam logic [7:0] FRZ  = 8'b0000_0010;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] LU   = 8'b0011_0100;
  localparam logic [7:0] ABT  = 8'b1111_0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int err = 0;
  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  wire [7:0] ctl = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we,
                    bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush, bus.mem_abort};
  function automatic logic [CNT_W-1:0] ex(int n);
    return CNT_W'(PERF * n);
  endfunction
  task automatic idle();
    bus.data_nstall = 1'b1;
    bus.branch_taken = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.mem_fault_clr = 1'b0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    idle();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.branch_taken = 1'b1;
    bus.data_nstall = 1'b0;
    bus.dmem_req = 1'b1;
    @(negedge clk);
    vec++; if (ctl !== RSTV) begin err++; $display("FAIL reset_ctl got %b want %b", ctl, RSTV); end
    next();
    idle();
    rst = 1'b0;
    @(negedge clk);
    vec++; if (ctl !== NORM) begin err++; $display("FAIL reset_idle got %b want %b", ctl, NORM); end
    vec++; if ({bus.mem_fault, bus.lu_stall_cnt, bus.flush_cnt, bus.mem_wait_cnt} !== '0) begin
      err++; $display("FAIL reset_state fault %b cnts %0d %0d %0d want all 0", bus.mem_fault,
                      bus.lu_stall_cnt, bus.flush_cnt, bus.mem_wait_cnt); end
    next();
  endtask
  task automatic test_load_use();
    pulse_reset();
    bus.data_nstall = 1'b0;
    @(negedge clk);
    vec++; if (ctl !== LU) begin err++; $display("FAIL lu_ctl got %b want %b", ctl, LU); end
    next();
    bus.data_nstall = 1'b1;
    @(negedge clk);
    vec++; if (ctl !== NORM) begin err++; $display("FAIL lu_release got %b want %b", ctl, NORM); end
    vec++; if (bus.lu_stall_cnt !== ex(1)) begin err++; $display("FAIL lu_cnt got %0d want %0d", bus.lu_stall_cnt, ex(1)); end
    next();
  endtask
  task automatic test_branch_over_stall();
    pulse_reset();
    bus.branch_taken = 1'b1;
    bus.data_nstall = 1'b0;
    @(negedge clk);
    vec++; if (ctl !== BR) begin err++; $display("FAIL br_ctl got %b want %b", ctl, BR); end
    next();
    idle();
    @(negedge clk);
    vec++; if (ctl !== NORM) begin err++; $display("FAIL br_single got %b want %b", ctl, NORM); end
    vec++; if (bus.flush_cnt !== ex(1)) begin err++; $display("FAIL br_flush_cnt got %0d want %0d", bus.flush_cnt, ex(1)); end
    vec++; if (bus.lu_stall_cnt !== ex(0)) begin err++; $display("FAIL br_lu_cnt got %0d want %0d", bus.lu_stall_cnt, ex(0)); end
    next();
  endtask
  task automatic test_mem_wait();
    pulse_reset();
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.branch_taken = (i == 1);
      bus.data_nstall = (i != 2);
      @(negedge clk);
      vec++; if (ctl !== FRZ) begin err++; $display("FAIL mw_frz%0d got %b want %b", i, ctl, FRZ); end
      next();
    end
    idle();
    bus.dmem_req = 1'b1;
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    vec++; if (ctl !== NORM) begin err++; $display("FAIL mw_release got %b want %b", ctl, NORM); end
    next();
    idle();
    @(negedge clk);
    vec++; if (bus.mem_wait_cnt !== ex(3)) begin err++; $display("FAIL mw_cnt got %0d want %0d", bus.mem_wait_cnt, ex(3)); end
    vec++; if ({bus.flush_cnt, bus.lu_stall_cnt} !== {ex(0), ex(0)}) begin
      err++; $display("FAIL mw_ignored flush %0d lu %0d want 0 0", bus.flush_cnt, bus.lu_stall_cnt); end
    vec++; if (bus.mem_fault !== 1'b0) begin err++; $display("FAIL mw_fault got %b want 0", bus.mem_fault); end
    next();
  endtask
  task automatic test_timeout();
    pulse_reset();
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec++; if (ctl !== FRZ) begin err++; $display("FAIL to_frz%0d got %b want %b", i, ctl, FRZ); end
      next();
    end
    @(negedge clk);
    vec++; if (ctl !== ABT) begin err++; $display("FAIL to_abort got %b want %b", ctl, ABT); end
    next();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec++; if ({ctl, bus.mem_fault} !== {NORM, 1'b1}) begin
        err++; $display("FAIL to_sticky%0d got %b/%b want %b/1", i, ctl, bus.mem_fault, NORM); end
      next();
    end
    bus.mem_fault_clr = 1'b1;
    next();
    bus.mem_fault_clr = 1'b0;
    @(negedge clk);
    vec++; if (bus.mem_fault !== 1'b0) begin err++; $display("FAIL to_clear got %b want 0", bus.mem_fault); end
    vec++; if (bus.mem_wait_cnt !== ex(4)) begin err++; $display("FAIL to_cnt got %0d want %0d", bus.mem_wait_cnt, ex(4)); end
    next();
  endtask
  task automatic test_tie();
    pulse_reset();
    bus.dmem_req = 1'b1;
    repeat (4) next();
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    vec++; if (ctl !== NORM) begin err++; $display("FAIL tie_ctl got %b want %b", ctl, NORM); end
    next();
    idle();
    @(negedge clk);
    vec++; if (bus.mem_fault !== 1'b0) begin err++; $display("FAIL tie_fault got %b want 0", bus.mem_fault); end
    next();
  endtask
  task automatic test_clr_race();
    pulse_reset();
    bus.dmem_req = 1'b1;
    repeat (4) next();
    bus.mem_fault_clr = 1'b1;
    @(negedge clk);
    vec++; if (ctl !== ABT) begin err++; $display("FAIL race_abort got %b want %b", ctl, ABT); end
    next();
    idle();
    @(negedge clk);
    vec++; if (bus.mem_fault !== 1'b1) begin err++; $display("FAIL race_fault got %b want 1", bus.mem_fault); end
    next();
  endtask
  task automatic test_reset_mid_wait();
    pulse_reset();
    bus.data_nstall = 1'b0;
    next();
    idle();
    bus.dmem_req = 1'b1;
    repeat (5) next();
    repeat (2) next();
    rst = 1'b1;
    @(negedge clk);
    vec++; if (ctl !== RSTV) begin err++; $display("FAIL rmw_ctl got %b want %b", ctl, RSTV); end
    next();
    rst = 1'b0;
    idle();
    @(negedge clk);
    vec++; if ({bus.mem_fault, bus.lu_stall_cnt, bus.mem_wait_cnt, ctl} !== {1'b0, ex(0), ex(0), NORM}) begin
      err++; $display("FAIL rmw_state fault %b lu %0d mw %0d ctl %b want 0 0 0 %b", bus.mem_fault,
                      bus.lu_stall_cnt, bus.mem_wait_cnt, ctl, NORM); end
    next();
    bus.dmem_req = 1'b1;
    repeat (4) next();
    @(negedge clk);
    vec++; if (ctl !== ABT) begin err++; $display("FAIL rmw_fresh got %b want %b", ctl, ABT); end
    next();
    idle();
    next();
  endtask
  task automatic test_back_to_back();
    pulse_reset();
    bus.dmem_req = 1'b1;
    repeat (2) next();
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    vec++; if (ctl !== NORM) begin err++; $display("FAIL b2b_release got %b want %b", ctl, NORM); end
    next();
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec++; if (ctl !== FRZ) begin err++; $display("FAIL b2b_frz%0d got %b want %b", i, ctl, FRZ); end
      next();
    end
    @(negedge clk);
    vec++; if (ctl !== ABT) begin err++; $display("FAIL b2b_abort got %b want %b", ctl, ABT); end
    next();
    idle();
    @(negedge clk);
    vec++; if (bus.mem_wait_cnt !== ex(6)) begin err++; $display("FAIL b2b_cnt got %0d want %0d", bus.mem_wait_cnt, ex(6)); end
    next();
  endtask
  task automatic test_saturation();
    pulse_reset();
    bus.data_nstall = 1'b0;
    repeat (20) next();
    bus.data_nstall = 1'b1;
    @(negedge clk);
    vec++; if (bus.lu_stall_cnt !== ex(15)) begin err++; $display("FAIL sat_cnt got %0d want %0d", bus.lu_stall_cnt, ex(15)); end
    next();
  endtask
  initial begin
    idle();
    next();
    test_reset();
    test_load_use();
    test_branch_over_stall();
    test_mem_wait();
    test_timeout();
    test_tie();
    test_clr_race();
    test_reset_mid_wait();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It arbitrates three hazard sources and drives every pipeline-register write enable and flush:
- the ID-stage load-use stall request (`data_nstall`, active-low);
- the EX-stage taken-branch redirect;
- a multi-cycle data-memory handshake in MEM.

It holds a small FSM that freezes the pipeline while data memory is busy, aborts the access after a bounded timeout, and optionally keeps performance counters.

## Interface
- `MEM_TIMEOUT`, default 255: maximum frozen cycles per data access before abort. Legal range is 2..255.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_nstall`  in  1  0 = load-use hazard in ID; stall IF/ID and insert a bubble.
- `branch_taken`  in  1  EX resolved a taken branch/jump; redirect the PC.
- `dmem_req`  in  1  MEM stage holds a load/store.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `mem_fault_clr`  in  1  clears `mem_fault`.
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`  out  1 each  pipeline register write enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1 each  load a bubble (NOP, no writes).
- `mem_abort`  out  1  one-cycle pulse; MEM drops its access as a bubble.
- `mem_fault`  out  1  sticky timeout flag.
- `lu_stall_cnt`, `flush_cnt`, `mem_wait_cnt`  out  `CNT_W` each  performance counters.

## Operation
- **FSM states:** RUN, WAIT. State resets to RUN and `wait_cnt` to 0.
- **`freeze` condition:**
  - in RUN: `dmem_req & ~dmem_ready`;
  - in WAIT: `~dmem_ready & dmem_req & (wait_cnt != MEM_TIMEOUT-1)`.
- **Transitions:**
  - RUN → WAIT on `dmem_req & ~dmem_ready`; `wait_cnt` is set to 0.
  - WAIT → RUN on `dmem_ready`, or when `dmem_req` is deasserted; neither case is a fault.
  - WAIT → RUN on timeout: `~dmem_ready & wait_cnt == MEM_TIMEOUT-1`. That cycle: `mem_abort=1`, `mem_fault` set, no freeze.
  - Otherwise WAIT stays in WAIT and `wait_cnt` increments.
  - If `dmem_ready` and timeout occur together, ready wins: no abort, no fault.
- **Output priority, highest first (outputs are combinational from state and inputs):**
  1. `rst`=1: all `*_we`=0, all flushes=1, `mem_abort`=0.
  2. `freeze`: `pc_we`=`if_id_we`=`id_ex_we`=`ex_mem_we`=0, `mem_wb_flush`=1. `branch_taken` and `data_nstall` are ignored because EX and ID hold their contents.
  3. `branch_taken`: all `we`=1, `if_id_flush`=`id_ex_flush`=1. This overrides a load-use stall in the same cycle.
  4. `~data_nstall`: `pc_we`=`if_id_we`=0, `id_ex_flush`=1, `id_ex_we`=`ex_mem_we`=1.
  5. Otherwise: all `we`=1, all flushes=0.
- **`mem_fault`:**
  - reset 0; set on timeout; cleared by `mem_fault_clr`;
  - if set and clear occur in the same cycle, set wins.
- **Counters** (saturate at all-ones, reset 0):
  - `lu_stall_cnt` +1 per cycle in which case 4 is applied;
  - `flush_cnt` +1 per cycle in which case 3 is applied;
  - `mem_wait_cnt` +1 per `freeze` cycle.

## Timing
- Zero-latency control: the outputs reflect the same-cycle inputs.
- A load-use stall lasts exactly as long as `data_nstall`=0, normally one cycle.
- A branch flush is a single cycle.
- A memory stall with ready arriving N cycles after the request freezes N cycles; the pipeline advances on the cycle `dmem_ready`=1.
- **Timeout:** at most `MEM_TIMEOUT` frozen cycles (one detect cycle in RUN plus `MEM_TIMEOUT`-1 in WAIT). The next cycle is the abort cycle.
- **Reset mid-WAIT:** the next cycle is in RUN with `wait_cnt`=0. `mem_fault` and the counters are cleared.
- **Back-to-back misses:** a new `dmem_req & ~dmem_ready` in the cycle after leaving WAIT re-enters WAIT with a fresh `wait_cnt`.

## Configuration
- **`PIPE_PERF_CNT_EN`:**
  - Defined: the three counters are implemented as above.
  - Undefined: the counter ports still exist but are tied to 0 and no counter flops are synthesized. All other behaviour is identical.

## Test plan
- **Load-use stall:** `data_nstall`=0 for 1 cycle, no other hazard → `pc_we`=`if_id_we`=0 and `id_ex_flush`=1 for exactly that cycle; `lu_stall_cnt`=1.
- **Branch overrides stall:** `branch_taken`=1 with `data_nstall`=0 → all `we`=1, `if_id_flush`=`id_ex_flush`=1; `flush_cnt`=1, `lu_stall_cnt`=0.
- **Memory wait:** `dmem_req`=1 with `dmem_ready` high 3 cycles later → frozen for 3 cycles, `mem_wb_flush`=1 during them, release on the ready cycle; `mem_wait_cnt`=3, no fault.
- **Timeout:** `MEM_TIMEOUT`=4, `dmem_req`=1, `dmem_ready` held 0 → 4 frozen cycles, then 1 cycle with `mem_abort`=1 and no freeze; `mem_fault`=1 until `mem_fault_clr`.
- **Tie and clear race:** `dmem_ready`=1 exactly at `wait_cnt`=`MEM_TIMEOUT`-1 → no abort, no fault. Separately, `mem_fault_clr` coincident with a timeout → `mem_fault` stays 1.
- **Reset mid-WAIT:** `rst` pulsed during WAIT → next cycle is RUN with all counters 0 and `mem_fault`=0. During `rst`, all `we`=0 and all flushes=1.
